// File: rtl/vec_spi_master.sv
// vec_spi_master: serialises one parallel view-vector frame into an SPI
// Mode 0 transaction (CS active-low, SCLK idle low, MSB first) for the
// raybox-zero vector slave port. Every output is a register fed from the
// current state, so pins lag the state register by one clock.
module vec_spi_master #(
  parameter int PAYLOAD_BITS = 74,
  parameter int HALF_PERIOD  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_start,
  input  logic [PAYLOAD_BITS-1:0] i_payload,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    vec_csb,
  output logic                    vec_sclk,
  output logic                    vec_mosi
);

  localparam int HP_W  = $clog2(HALF_PERIOD + 1);
  localparam int BIT_W = (PAYLOAD_BITS > 1) ? $clog2(PAYLOAD_BITS) : 1;
  localparam logic [HP_W-1:0]  HP_RELOAD = HP_W'(HALF_PERIOD - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(PAYLOAD_BITS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    HIGH  = 3'd2,
    LOW   = 3'd3,
    GAP   = 3'd4
  } state_e;

  state_e                  state_q, state_d;
  logic [HP_W-1:0]         hp_q, hp_d;
  logic [BIT_W-1:0]        bit_q, bit_d;
  logic [PAYLOAD_BITS-1:0] shift_q, shift_d;
  logic                    done_pend_q, done_pend_d;
  logic                    busy_q, done_q, csb_q, sclk_q, mosi_q;
  logic                    hp_expired;
  logic                    frame_active;

  assign hp_expired   = (hp_q == '0);
  assign frame_active = (state_q == SETUP) || (state_q == HIGH) || (state_q == LOW);

  // Next-state logic: phase sequencing, half-period countdown, bit shifting.
  always_comb begin
    state_d     = state_q;
    hp_d        = hp_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    done_pend_d = 1'b0;
    if (state_q != IDLE && !hp_expired) begin
      hp_d = hp_q - HP_W'(1);
    end
    case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d = SETUP;
          hp_d    = HP_RELOAD;
          bit_d   = BIT_LAST;
          shift_d = i_payload;
        end
      end
      SETUP: begin
        if (hp_expired) begin
          state_d = HIGH;
          hp_d    = HP_RELOAD;
        end
      end
      HIGH: begin
        if (hp_expired) begin
          state_d = LOW;
          hp_d    = HP_RELOAD;
          // The last bit stays on MOSI through the final LOW (CS hold).
          if (bit_q != '0) begin
            shift_d = shift_q << 1;
          end
        end
      end
      LOW: begin
        if (hp_expired) begin
          hp_d = HP_RELOAD;
          if (bit_q != '0) begin
            state_d = HIGH;
            bit_d   = bit_q - BIT_W'(1);
          end else begin
            state_d = GAP;
          end
        end
      end
      GAP: begin
        if (hp_expired) begin
          state_d     = IDLE;
          done_pend_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state registers; reset abandons any frame in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      hp_q        <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      done_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hp_q        <= hp_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      done_pend_q <= done_pend_d;
    end
  end

  // Registered pins decoded from the current phase (one clock behind state).
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      csb_q  <= 1'b1;
      sclk_q <= 1'b0;
      mosi_q <= 1'b0;
    end else begin
      busy_q <= (state_q != IDLE);
      done_q <= done_pend_q;
      csb_q  <= !frame_active;
      sclk_q <= (state_q == HIGH);
      mosi_q <= frame_active ? shift_q[PAYLOAD_BITS-1] : 1'b0;
    end
  end

  assign o_busy   = busy_q;
  assign o_done   = done_q;
  assign vec_csb  = csb_q;
  assign vec_sclk = sclk_q;
  assign vec_mosi = mosi_q;

endmodule
